// File: rtl/pattern_tx_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state encoding and the
// power-up pattern (also the pattern the 1101 detector bench looks for).
package pattern_tx_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
endpackage

// File: rtl/pattern_tx_shreg.sv
// WIDTH-bit parallel-load, shift-left register; exposes only its MSB.
// Load takes priority over shift.
module pattern_tx_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);
  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];
endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit word MSB-first, repeat_n+1 times, then pulses done.
// Optional inter-repetition idle cycle when built with PATTERN_TX_GAP_EN.
module pattern_tx #(
  parameter int               WIDTH           = 4,
  parameter int               CNT_W           = 8,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(pattern_tx_pkg::DEFAULT_PATTERN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             ready,
  output logic             dout,
  output logic             bit_valid,
  output logic             done
);
  import pattern_tx_pkg::*;

  localparam int               BW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_next;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [WIDTH-1:0] pat_reg;
  logic             sh_load, sh_shift, sh_msb;
  logic [WIDTH-1:0] load_data;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    state_next = state;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    load_data  = pat_reg;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          sh_load    = 1'b1;
          load_data  = pattern;
        end
      end
      SEND: begin
        if (last_bit) begin
          if (rep_cnt != '0) begin
            // Reload for the next repetition while the last bit is on the wire.
            sh_load = 1'b1;
`ifdef PATTERN_TX_GAP_EN
            state_next = GAP;
`endif
          end else begin
            state_next = DONE;
          end
        end else begin
          sh_shift = 1'b1;
        end
      end
`ifdef PATTERN_TX_GAP_EN
      GAP:  state_next = SEND;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      pat_reg <= DEFAULT_PATTERN;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        pat_reg <= pattern;
        rep_cnt <= repeat_n;
        bit_cnt <= '0;
      end else if (state == SEND) begin
        if (last_bit) begin
          bit_cnt <= '0;
          if (rep_cnt != '0) rep_cnt <= rep_cnt - 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  pattern_tx_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .data  (load_data),
    .msb   (sh_msb)
  );

  // Outputs decode flops only; nothing from the inputs reaches them combinationally.
  assign ready     = (state == IDLE);
  assign bit_valid = (state == SEND);
  assign dout      = (state == SEND) & sh_msb;
  assign done      = (state == DONE);
endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: random and directed transfers against a bit-queue model.
module tb_pattern_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] repeat_n = '0;
  logic       ready, dout, bit_valid, done;

  logic       start8 = 1'b0;
  logic [7:0] pattern8 = '0;
  logic [7:0] rep8 = '0;
  logic       ready8, dout8, bit_valid8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_tx #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .ready(ready), .dout(dout), .bit_valid(bit_valid), .done(done)
  );

  pattern_tx #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .pattern(pattern8), .repeat_n(rep8),
    .ready(ready8), .dout(dout8), .bit_valid(bit_valid8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected stream: pattern bits MSB-first, repeated r+1 times, optional idle slot between copies.
  task automatic xfer(input logic [3:0] p, input logic [7:0] r, input bit noise, input string tag);
    bit ev[$];
    bit ed[$];
    int waitc = 0;
    while (ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, "_ready_before"}, ready, 1);
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = 3; i >= 0; i--) begin
        ev.push_back(1'b1);
        ed.push_back(p[i]);
      end
`ifdef PATTERN_TX_GAP_EN
      if (k < int'(r)) begin
        ev.push_back(1'b0);
        ed.push_back(1'b0);
      end
`endif
    end
    start = 1'b1; pattern = p; repeat_n = r;
    @(negedge clk);
    foreach (ev[n]) begin
      chk({tag, "_dout"}, dout, ed[n]);
      chk({tag, "_bit_valid"}, bit_valid, ev[n]);
      chk({tag, "_ready_busy"}, ready, 0);
      chk({tag, "_done_early"}, done, 0);
      start    = noise;
      pattern  = noise ? 4'b0000 : 4'($urandom);
      repeat_n = 8'($urandom);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready_in_done"}, ready, 0);
    chk({tag, "_dout_in_done"}, dout, 0);
    chk({tag, "_valid_in_done"}, bit_valid, 0);
    start = noise;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_ready_after"}, ready, 1);
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_valid_after"}, bit_valid, 0);
  endtask

  initial begin
    int cyc, nb, done_cnt, done_cyc, exp_done_cyc;

    #12;
    chk("rst_ready", ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", ready, 1);
    chk("idle_dout", dout, 0);

    xfer(4'b1101, 8'd0, 1'b0, "single");
    xfer(4'b1101, 8'd2, 1'b0, "repeat3");
    xfer(4'b1101, 8'd0, 1'b1, "busy_start");
    xfer(4'b1011, 8'd1, 1'b0, "two_copies");
    xfer(4'b0001, 8'd1, 1'b1, "lsb_only");
    xfer(4'b1000, 8'd0, 1'b0, "msb_only");
    for (int t = 0; t < 8; t++) begin
      xfer(4'($urandom), 8'($urandom_range(0, 3)), 1'($urandom), "rand");
    end

    // Reset in the third cycle of a two-copy send.
    start = 1'b1; pattern = 4'($urandom); repeat_n = 8'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", ready, 1);
    xfer(4'b1101, 8'd1, 1'b0, "after_rst");

    // Wide build: 8'h80 sent 256 times.
    start8 = 1'b1; pattern8 = 8'h80; rep8 = 8'd255;
    @(negedge clk);
    start8 = 1'b0; pattern8 = 8'($urandom); rep8 = 8'($urandom);
    cyc = 1; nb = 0; done_cnt = 0; done_cyc = 0;
    while (cyc <= 3000 && done_cyc == 0) begin
      if (bit_valid8 === 1'b1) begin
        chk("w8_bit", dout8, (nb % 8 == 0) ? 1 : 0);
        nb++;
      end
      if (done8 === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
`ifdef PATTERN_TX_GAP_EN
    exp_done_cyc = 2049 + 255;
`else
    exp_done_cyc = 2049;
`endif
    chk("w8_bits", nb, 2048);
    chk("w8_done_cycle", done_cyc, exp_done_cyc);
    for (int c = 0; c < 3; c++) begin
      if (done8 === 1'b1) done_cnt++;
      @(negedge clk);
    end
    chk("w8_done_count", done_cnt, 1);
    chk("w8_ready", ready8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter that drives a single-bit stream MSB-first from a parallel pattern word, optionally repeated a programmable number of times. It is the sending end of the serial-pattern path. Its `dout` connects directly to the `a` input of the team's Moore pattern recognizer (1101 detector), so benches and on-chip self-test can exercise that detector. Handshake is start/ready; completion is signalled with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 4: pattern length in bits (≥2).
- `CNT_W`, 8: width of the repeat count.
- `DEFAULT_PATTERN`, 4'b1101: value `dout` pattern register holds after reset (not transmitted unless started).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `pattern`  in  WIDTH  word to send; sampled on accept.
- `repeat_n`  in  CNT_W  extra repetitions; sampled on accept (total sends = `repeat_n`+1).
- `ready`  out  1  high in IDLE only.
- `dout`  out  1  serial data, MSB-first, registered.
- `bit_valid`  out  1  high on every cycle `dout` carries a pattern bit.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, `ready`=1, `dout`=0, `bit_valid`=0, `done`=0, bit counter=0, repeat counter=0, pattern register=`DEFAULT_PATTERN`.
- FSM states:
  - IDLE: `ready`=1, `dout`=0. On `start`=1, capture `pattern` into the pattern register and shift register, capture `repeat_n` into the repeat counter, and go to SEND.
  - SEND: `bit_valid`=1, `dout`=shift-register MSB; shift left each cycle and increment the bit counter (0..WIDTH-1).
    - At bit WIDTH-1 with repeat counter >0: decrement the counter, reload the shift register from the pattern register, clear the bit counter, and stay in SEND (or go to GAP, see Configuration).
    - At bit WIDTH-1 with repeat counter =0: go to DONE.
  - GAP (macro only): one cycle with `dout`=0 and `bit_valid`=0, then SEND.
  - DONE: `done`=1, `dout`=0, `ready`=0; next state is IDLE unconditionally.
- Repetitions are back-to-back by default. With `pattern`=1101 this yields an overlapping stream on which the detector fires once per pattern.
- `start` outside IDLE (including DONE) is ignored, not queued.
- Changes on `pattern` or `repeat_n` after accept have no effect on the transfer in progress.
- Reset mid-transfer: the transfer aborts immediately, outputs take their reset values, and no `done` pulse is issued.
- Counter widths: bit counter is $clog2(WIDTH) bits; repeat counter is CNT_W bits and never wraps, because it is only decremented when nonzero.

## Timing
- Start sampled at edge E → first bit on `dout` is valid in cycle E+1, and `ready` drops in E+1.
- One bit per cycle. Total SEND cycles = WIDTH×(`repeat_n`+1), plus `repeat_n` GAP cycles when the macro is defined.
- `done` is high in the single cycle after the last bit; `ready` returns the cycle after that.
- Minimum spacing between accepted starts: WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `PATTERN_TX_GAP_EN`:
  - Defined: the GAP state exists, and one idle cycle (`dout`=0, `bit_valid`=0) is inserted between consecutive repetitions.
  - Undefined: GAP is not compiled in, and repetitions are contiguous.
- The final repetition is never followed by a gap in either build.

## Structure
- Package `pattern_tx_pkg`: state encoding constants (IDLE, SEND, GAP, DONE as a 2-bit localparam set) and the `DEFAULT_PATTERN` constant 4'b1101, shared with the detector bench.
- Sub-module `pattern_tx_shreg`: WIDTH-bit parallel-load, shift-left register.
  - Inputs: `load`, `shift`, parallel data.
  - Output: MSB.
- FSM and counters stay in the top level.

## Test plan
- Single send: `pattern`=1101, `repeat_n`=0, `start` at cycle 0 → `dout`=1,1,0,1 in cycles 1–4 with `bit_valid`=1; `done`=1 in cycle 5; `ready`=1 in cycle 6.
- Repeat: `pattern`=1101, `repeat_n`=2 → 12 contiguous bits 110111011101 in cycles 1–12; `done` in cycle 13; the chained detector pulses `y` three times.
- Busy start: assert `start` with `pattern`=0000 in cycles 2 and 5 of the single-send case → stream unchanged (1101), exactly one `done`.
- Reset mid-frame: assert `reset` in cycle 3 of a `repeat_n`=1 send → in that cycle `dout`=0, `bit_valid`=0, `ready`=1; no `done`; a fresh start afterwards sends correctly.
- Gap build (`PATTERN_TX_GAP_EN`): `pattern`=1011, `repeat_n`=1 → `dout` 1,0,1,1,0,1,0,1,1 with `bit_valid` low in cycle 5 only; `done` in cycle 10.
- Width corner: WIDTH=8, `pattern`=8'h80, `repeat_n`=255 → 2048 bits, each 8-bit group 10000000, and a single `done` at cycle 2049.
